us_cmd_gen: RTL and testbench

Producer side of the upstream command FIFO. It accepts decoded non-posted requests from the PCIe RX engine and performs the register read or write each one needs. It then formats a 128-bit upstream command word and pushes it into the us_cmd FIFO. The command-processing FSM on the far side of that FIFO turns each word into a Cpl/CplD. This block throttles itself on FIFO full and on an outstanding-command limit, which it retires using the consumer's completion pulse.

---
 rtl/us_cmd_gen_pkg.sv | 64 ++++++
 rtl/us_cmd_credit.sv | 41 ++++
 rtl/us_cmd_gen.sv | 134 +++++++++++++
 tb/tb_us_cmd_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_cmd_gen_pkg.sv
// Shared definitions for the upstream command word: type codes, request kinds,
// bit-field positions (also used by the consumer FSM) and the word packer.
package us_cmd_gen_pkg;

  localparam logic [1:0] US_CMD_CPL_TYPE  = 2'b01;
  localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;

  localparam logic [1:0] REQ_CMD_MRD32 = 2'b00;
  localparam logic [1:0] REQ_CMD_IORD  = 2'b01;
  localparam logic [1:0] REQ_CMD_IOWR  = 2'b10;
  localparam logic [1:0] REQ_CMD_UNSUP = 2'b11;

  localparam int US_CMD_DATA_LSB = 96;
  localparam int US_CMD_TYPE_LSB = 62;
  localparam int US_CMD_TC_LSB   = 52;
  localparam int US_CMD_TD_BIT   = 51;
  localparam int US_CMD_EP_BIT   = 50;
  localparam int US_CMD_ATTR_LSB = 48;
  localparam int US_CMD_LEN_LSB  = 38;
  localparam int US_CMD_RID_LSB  = 22;
  localparam int US_CMD_TAG_LSB  = 14;
  localparam int US_CMD_BE_LSB   = 6;
  localparam int US_CMD_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_PUSH    = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
  } req_hdr_t;

  function automatic logic [127:0] us_cmd_pack(input logic [1:0] cmd_type,
                                               input req_hdr_t hdr,
                                               input logic [31:0] data);
    logic [127:0] w;
    w = '0;
    w[US_CMD_DATA_LSB +: 32] = data;
    w[US_CMD_TYPE_LSB +: 2]  = cmd_type;
    w[US_CMD_TC_LSB +: 3]    = hdr.tc;
    w[US_CMD_TD_BIT]         = hdr.td;
    w[US_CMD_EP_BIT]         = hdr.ep;
    w[US_CMD_ATTR_LSB +: 2]  = hdr.attr;
    w[US_CMD_LEN_LSB +: 10]  = hdr.len;
    w[US_CMD_RID_LSB +: 16]  = hdr.rid;
    w[US_CMD_TAG_LSB +: 8]   = hdr.tag;
    w[US_CMD_BE_LSB +: 8]    = hdr.be;
    w[US_CMD_ADDR_LSB +: 6]  = hdr.addr[5:0];
    return w;
  endfunction

endpackage

// File: rtl/us_cmd_credit.sv
// Outstanding-command credit tracker: push/completion counter, throttle
// compare against MAX_OUTSTANDING and a sticky completion-underflow flag.
module us_cmd_credit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_compl,
  output logic [3:0] o_outstanding,
  output logic       o_can_accept,
  output logic       o_underflow
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0] r_count;
  logic       r_underflow;

  // A push and a completion in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      case ({i_push, i_compl})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01: begin
          if (r_count == 4'd0) r_underflow <= 1'b1;
          else                 r_count     <= r_count - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_outstanding = r_count;
  assign o_can_accept  = (r_count < MAX_CNT);
  assign o_underflow   = r_underflow;

endmodule

// File: rtl/us_cmd_gen.sv
// Upstream command generator: performs the register access for each non-posted
// request and pushes a Cpl/CplD command word. Optional: US_CMD_DROP_POISONED_EN.
module us_cmd_gen
  import us_cmd_gen_pkg::*;
#(
  parameter int RD_LATENCY      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_cmd_i,
  input  logic [2:0]   req_tc_i,
  input  logic         req_td_i,
  input  logic         req_ep_i,
  input  logic [1:0]   req_attr_i,
  input  logic [9:0]   req_len_i,
  input  logic [15:0]  req_rid_i,
  input  logic [7:0]   req_tag_i,
  input  logic [7:0]   req_be_i,
  input  logic [12:0]  req_addr_i,
  input  logic [31:0]  req_data_i,
  output logic         reg_rd_en_o,
  input  logic [31:0]  reg_rd_data_i,
  output logic         reg_wr_en_o,
  output logic [31:0]  reg_wr_data_o,
  output logic [3:0]   reg_wr_be_o,
  output logic [10:0]  reg_addr_o,
  output logic         us_cmd_fifo_wr_en_o,
  output logic [127:0] us_cmd_fifo_din_o,
  input  logic         us_cmd_fifo_full_i,
  input  logic         up_wr_cmd_compl_i,
  output logic [3:0]   outstanding_o,
  output logic         compl_underflow_o
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_t     r_state;
  state_t     w_state_next;
  req_hdr_t   r_hdr;
  logic [1:0] r_type;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_data;
  logic [2:0] r_lat_cnt;

  logic w_accept;
  logic w_can_accept;
  logic w_push;
  logic w_wr_allow;

  assign w_accept    = req_valid_i & req_ready_o;
  assign req_ready_o = ~rst & (r_state == ST_IDLE) & w_can_accept;
  assign w_push      = (r_state == ST_PUSH) & ~us_cmd_fifo_full_i;

`ifdef US_CMD_DROP_POISONED_EN
  assign w_wr_allow = ~r_hdr.ep;
`else
  assign w_wr_allow = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (req_cmd_i)
            REQ_CMD_MRD32, REQ_CMD_IORD: w_state_next = ST_RD;
            REQ_CMD_IOWR:                w_state_next = ST_WR;
            REQ_CMD_UNSUP:               w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_RD:      w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (r_lat_cnt == 3'd0) w_state_next = ST_PUSH;
      ST_WR:      w_state_next = ST_PUSH;
      ST_PUSH:    if (w_push) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Read data is cleared on accept so a CPL word always carries zero payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr     <= '0;
      r_type    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_hdr     <= '{tc: req_tc_i, td: req_td_i, ep: req_ep_i, attr: req_attr_i,
                       len: req_len_i, rid: req_rid_i, tag: req_tag_i,
                       be: req_be_i, addr: req_addr_i};
        r_type    <= (req_cmd_i == REQ_CMD_IOWR) ? US_CMD_CPL_TYPE : US_CMD_CPLD_TYPE;
        r_wr_data <= req_data_i;
        r_rd_data <= '0;
      end
      if (r_state == ST_RD) begin
        r_lat_cnt <= LAT_LAST;
      end else if (r_state == ST_RD_WAIT) begin
        if (r_lat_cnt == 3'd0) r_rd_data <= reg_rd_data_i;
        else                   r_lat_cnt <= r_lat_cnt - 3'd1;
      end
    end
  end

  assign reg_rd_en_o         = (r_state == ST_RD);
  assign reg_wr_en_o         = (r_state == ST_WR) & w_wr_allow;
  assign reg_wr_data_o       = r_wr_data;
  assign reg_wr_be_o         = r_hdr.be[3:0];
  assign reg_addr_o          = r_hdr.addr[12:2];
  assign us_cmd_fifo_wr_en_o = w_push;
  assign us_cmd_fifo_din_o   = us_cmd_pack(r_type, r_hdr, r_rd_data);

  us_cmd_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_compl       (up_wr_cmd_compl_i),
    .o_outstanding (outstanding_o),
    .o_can_accept  (w_can_accept),
    .o_underflow   (compl_underflow_o)
  );

endmodule

// File: tb/tb_us_cmd_gen.sv
// Self-checking bench for us_cmd_gen: directed scenarios plus randomized
// requests against a transaction-level model of timing, word format and credits.
module tb_us_cmd_gen;

  localparam int L    = 2;
  localparam int MAXO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [1:0]   req_cmd_i = '0;
  logic [2:0]   req_tc_i = '0;
  logic         req_td_i = 1'b0;
  logic         req_ep_i = 1'b0;
  logic [1:0]   req_attr_i = '0;
  logic [9:0]   req_len_i = '0;
  logic [15:0]  req_rid_i = '0;
  logic [7:0]   req_tag_i = '0;
  logic [7:0]   req_be_i = '0;
  logic [12:0]  req_addr_i = '0;
  logic [31:0]  req_data_i = '0;
  logic         reg_rd_en_o;
  logic [31:0]  reg_rd_data_i;
  logic         reg_wr_en_o;
  logic [31:0]  reg_wr_data_o;
  logic [3:0]   reg_wr_be_o;
  logic [10:0]  reg_addr_o;
  logic         us_cmd_fifo_wr_en_o;
  logic [127:0] us_cmd_fifo_din_o;
  logic         us_cmd_fifo_full_i = 1'b0;
  logic         up_wr_cmd_compl_i = 1'b0;
  logic [3:0]   outstanding_o;
  logic         compl_underflow_o;

  us_cmd_gen #(.RD_LATENCY(L), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cmd_i(req_cmd_i),
    .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i), .req_attr_i(req_attr_i),
    .req_len_i(req_len_i), .req_rid_i(req_rid_i), .req_tag_i(req_tag_i), .req_be_i(req_be_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .reg_rd_en_o(reg_rd_en_o), .reg_rd_data_i(reg_rd_data_i), .reg_wr_en_o(reg_wr_en_o),
    .reg_wr_data_o(reg_wr_data_o), .reg_wr_be_o(reg_wr_be_o), .reg_addr_o(reg_addr_o),
    .us_cmd_fifo_wr_en_o(us_cmd_fifo_wr_en_o), .us_cmd_fifo_din_o(us_cmd_fifo_din_o),
    .us_cmd_fifo_full_i(us_cmd_fifo_full_i), .up_wr_cmd_compl_i(up_wr_cmd_compl_i),
    .outstanding_o(outstanding_o), .compl_underflow_o(compl_underflow_o)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_out   = 0;
  bit   m_unf   = 1'b0;
  bit   e_rd = 1'b0, e_wr = 1'b0, e_push = 1'b0;
  logic [31:0] rd_value = '0;
  int   rd_cnt = 0;

  // Register file model: read data is valid only in the cycle L after the strobe.
  always @(negedge clk) begin
    if (rst)              rd_cnt = 0;
    else if (reg_rd_en_o) rd_cnt = L + 1;
    else if (rd_cnt > 0)  rd_cnt--;
    reg_rd_data_i = (rd_cnt == 1) ? rd_value : $urandom;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobes are compared against this cycle's expectation, then the credit model advances.
  task automatic tick();
    #1;
    check("rd_en", reg_rd_en_o, e_rd);
    check("wr_en", reg_wr_en_o, e_wr);
    check("push", us_cmd_fifo_wr_en_o, e_push);
    if (rst) begin
      m_out = 0;
      m_unf = 1'b0;
    end else if (e_push && !up_wr_cmd_compl_i) begin
      m_out++;
    end else if (!e_push && up_wr_cmd_compl_i) begin
      if (m_out == 0) m_unf = 1'b1;
      else            m_out--;
    end
    e_rd = 1'b0; e_wr = 1'b0; e_push = 1'b0;
    @(posedge clk); #1;
    check("outstanding", outstanding_o, m_out);
    check("underflow", compl_underflow_o, m_unf);
  endtask

  task automatic compl_pulse();
    up_wr_cmd_compl_i = 1'b1;
    tick();
    up_wr_cmd_compl_i = 1'b0;
  endtask

  task automatic drain();
    while (m_out > 0) compl_pulse();
  endtask

  function automatic logic [127:0] exp_word(input logic [31:0] rdata);
    logic [127:0] w;
    w = '0;
    w[127:96] = (req_cmd_i == 2'b10) ? 32'h0 : rdata;
    w[63:62]  = (req_cmd_i == 2'b10) ? 2'b01 : 2'b10;
    w[54:52]  = req_tc_i;
    w[51]     = req_td_i;
    w[50]     = req_ep_i;
    w[49:48]  = req_attr_i;
    w[47:38]  = req_len_i;
    w[37:22]  = req_rid_i;
    w[21:14]  = req_tag_i;
    w[13:6]   = req_be_i;
    w[5:0]    = req_addr_i[5:0];
    return w;
  endfunction

  task automatic rand_fields();
    req_cmd_i  = 2'($urandom_range(0, 3));
    req_tc_i   = 3'($urandom);
    req_td_i   = 1'($urandom);
    req_ep_i   = 1'($urandom);
    req_attr_i = 2'($urandom);
    req_len_i  = 10'($urandom);
    req_rid_i  = 16'($urandom);
    req_tag_i  = 8'($urandom);
    req_be_i   = 8'($urandom);
    req_addr_i = 13'($urandom);
    req_data_i = $urandom;
    rd_value   = $urandom;
  endtask

  // One request from offer to push, using the current req_* fields.
  task automatic do_req(input int stall, input bit compl_at_push);
    logic [127:0] exp;
    logic [1:0]   cmd;
    logic [12:0]  a;
    logic [31:0]  d;
    logic [7:0]   b;
    logic         ep;
    int           waitc;
    waitc = 0;
    req_valid_i = 1'b1;
    #1;
    forever begin
      check("ready", req_ready_o, (m_out < MAXO));
      if (req_ready_o) break;
      if (waitc == 20) begin
        check("accept_timeout", 1'b0, 1'b1);
        req_valid_i = 1'b0;
        return;
      end
      tick();
      waitc++;
    end
    exp = exp_word(rd_value);
    cmd = req_cmd_i; a = req_addr_i; d = req_data_i; b = req_be_i; ep = req_ep_i;
    tick();
    req_valid_i = 1'b0;
    req_addr_i = 13'($urandom); req_data_i = $urandom; req_be_i = 8'($urandom);
    req_ep_i = 1'($urandom); req_cmd_i = 2'($urandom);
    $display("[TB] txn cmd=%0d addr=%04h tag=%02h stall=%0d outstanding=%0d", cmd, a, exp[21:14], stall, m_out);
    if (cmd == 2'b11) begin
      check("ready_after_unsup", req_ready_o, (m_out < MAXO));
      return;
    end
    check("reg_addr", reg_addr_o, a[12:2]);
    if (cmd == 2'b10) begin
`ifdef US_CMD_DROP_POISONED_EN
      e_wr = !ep;
`else
      e_wr = 1'b1;
`endif
      check("wr_data", reg_wr_data_o, d);
      check("wr_be", reg_wr_be_o, b[3:0]);
      tick();
    end else begin
      e_rd = 1'b1;
      tick();
      repeat (L) tick();
    end
    us_cmd_fifo_full_i = (stall > 0);
    #1;
    for (int i = 0; i < stall; i++) begin
      check("din_stall", us_cmd_fifo_din_o, exp);
      check("addr_hold", reg_addr_o, a[12:2]);
      tick();
    end
    us_cmd_fifo_full_i = 1'b0;
    e_push = 1'b1;
    if (compl_at_push) up_wr_cmd_compl_i = 1'b1;
    #1;
    check("din", us_cmd_fifo_din_o, exp);
    tick();
    up_wr_cmd_compl_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {req_ready_o, reg_rd_en_o, reg_wr_en_o, reg_wr_data_o, reg_wr_be_o,
                       reg_addr_o, us_cmd_fifo_wr_en_o, outstanding_o, compl_underflow_o}, '0);
    check("rst_din", us_cmd_fifo_din_o, '0);
    rst = 1'b0;
    tick();

    // Directed MRd32 and IOWr
    rand_fields();
    req_cmd_i = 2'b00; req_tag_i = 8'h15; req_addr_i = 13'h0104; rd_value = 32'hDEADBEEF;
    do_req(0, 1'b0);
    rand_fields();
    req_cmd_i = 2'b10; req_data_i = 32'h12345678; req_be_i = 8'h0F; req_ep_i = 1'b0;
    do_req(0, 1'b0);

    // Throttle at MAX_OUTSTANDING, then retire one credit
    drain();
    for (int i = 0; i < MAXO; i++) begin
      rand_fields();
      req_cmd_i = 2'b00;
      do_req(0, 1'b0);
    end
    check("throttled", req_ready_o, 1'b0);
    rand_fields();
    req_cmd_i = 2'b00;
    req_valid_i = 1'b1;
    repeat (3) begin
      tick();
      check("throttled_hold", req_ready_o, 1'b0);
    end
    compl_pulse();
    do_req(0, 1'b1);
    check("compl_with_push", outstanding_o, 4'(MAXO - 1));

    // FIFO full for 10 cycles in PUSH
    drain();
    rand_fields();
    req_cmd_i = 2'b01;
    do_req(10, 1'b0);

    // Poisoned IOWr
    rand_fields();
    req_cmd_i = 2'b10; req_ep_i = 1'b1;
    do_req(0, 1'b0);

    // Underflow, then reset in the middle of RD_WAIT
    drain();
    compl_pulse();
    check("underflow_set", compl_underflow_o, 1'b1);
    rand_fields();
    req_cmd_i = 2'b00;
    req_valid_i = 1'b1;
    #1;
    check("ready_pre_rst", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    e_rd = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_outs", {req_ready_o, reg_rd_en_o, reg_wr_en_o, reg_wr_data_o, reg_wr_be_o,
                           reg_addr_o, us_cmd_fifo_wr_en_o, outstanding_o, compl_underflow_o}, '0);
    check("rst_mid_din", us_cmd_fifo_din_o, '0);
    rst = 1'b0;
    repeat (L + 3) tick();

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      rand_fields();
      if (m_out == MAXO || (m_out > 0 && $urandom_range(0, 1) == 1)) compl_pulse();
      do_req($urandom_range(0, 3), (m_out > 0) && ($urandom_range(0, 3) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
